// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and default widths for the cacheline arbiter.
// Client ids, FSM states and the grant-vector bit positions live here.
package cacheline_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  // Bit positions within the one-hot grant vector.
  localparam int unsigned IdxI    = 0;
  localparam int unsigned IdxLsq  = 1;
  localparam int unsigned IdxPref = 2;

  typedef enum logic [1:0] {
    CLI_NONE = 2'd0,
    CLI_I    = 2'd1,
    CLI_LSQ  = 2'd2,
    CLI_PREF = 2'd3
  } client_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic client_e onehot_to_client(input logic [2:0] grant);
    client_e cli;
    case (grant)
      3'b001:  cli = CLI_I;
      3'b010:  cli = CLI_LSQ;
      3'b100:  cli = CLI_PREF;
      default: cli = CLI_NONE;
    endcase
    return cli;
  endfunction

endpackage

// File: rtl/arb_grant_select.sv
// Combinational grant picker: one-hot grant among icache, LSQ and prefetcher.
// Each request vector is {write, read}; either bit set means the client is requesting.
module arb_grant_select
  import cacheline_arbiter_pkg::*;
#(
  parameter bit DemandRr = 1'b1
) (
  input  logic [1:0] i_req_i,
  input  logic [1:0] lsq_req_i,
  input  logic [1:0] pref_req_i,
  input  client_e    rr_last_i,
  input  logic       force_pref_i,
  output logic [2:0] grant_o
);

  logic i_v, lsq_v, pref_v;

  assign i_v    = |i_req_i;
  assign lsq_v  = |lsq_req_i;
  assign pref_v = |pref_req_i;

  always_comb begin
    grant_o = '0;
    if (pref_v && force_pref_i) begin
      grant_o[IdxPref] = 1'b1;
    end else if (i_v && lsq_v) begin
      // Round-robin hands the line to whichever demand client did not win last.
      if (DemandRr && (rr_last_i == CLI_LSQ)) begin
        grant_o[IdxI] = 1'b1;
      end else begin
        grant_o[IdxLsq] = 1'b1;
      end
    end else if (lsq_v) begin
      grant_o[IdxLsq] = 1'b1;
    end else if (i_v) begin
      grant_o[IdxI] = 1'b1;
    end else if (pref_v) begin
      grant_o[IdxPref] = 1'b1;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Serialises icache, LSQ and prefetcher line transactions onto one pmem port.
// IDLE grants and latches, BUSY drives pmem until pmem_resp, DONE blocks one cycle.
module cacheline_arbiter #(
  parameter int unsigned ADDR_W      = cacheline_arbiter_pkg::ADDR_W,
  parameter int unsigned LINE_W      = cacheline_arbiter_pkg::LINE_W,
  parameter int unsigned DEMAND_RR   = 1,
  parameter int unsigned PREF_STARVE = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read_cla,
  input  logic              i_pmem_write_cla,
  input  logic [ADDR_W-1:0] i_pmem_address_cla,
  input  logic [LINE_W-1:0] i_pmem_wdata_256_cla,
  output logic              i_pmem_resp_cla,
  output logic [LINE_W-1:0] i_pmem_rdata_256_cla,

  input  logic              lsq_pmem_read_cla,
  input  logic              lsq_pmem_write_cla,
  input  logic [ADDR_W-1:0] lsq_pmem_address_cla,
  input  logic [LINE_W-1:0] lsq_pmem_wdata_256_cla,
  output logic              lsq_pmem_resp_cla,
  output logic [LINE_W-1:0] lsq_pmem_rdata_256_cla,

  input  logic              pref_pmem_read_cla,
  input  logic              pref_pmem_write_cla,
  input  logic [ADDR_W-1:0] pref_pmem_address_cla,
  input  logic [LINE_W-1:0] pref_pmem_wdata_256_cla,
  output logic              pref_pmem_resp_cla,
  output logic [LINE_W-1:0] pref_pmem_rdata_256_cla,

  output logic              arbiter_idle,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata_256,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata_256
);

  import cacheline_arbiter_pkg::*;

  localparam int unsigned StarveW = (PREF_STARVE > 0) ? $clog2(PREF_STARVE + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(PREF_STARVE);

  state_e              state_q, state_d;
  client_e             owner_q, owner_d;
  client_e             rr_q, rr_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [StarveW-1:0]  starve_q, starve_d;

  logic [1:0] i_req, lsq_req, pref_req;
  logic [2:0] grant;
  client_e    gnt_client;
  logic       pref_pending;
  logic       force_pref;
  logic       busy, finish;

  assign i_req        = {i_pmem_write_cla, i_pmem_read_cla};
  assign lsq_req      = {lsq_pmem_write_cla, lsq_pmem_read_cla};
  assign pref_req     = {pref_pmem_write_cla, pref_pmem_read_cla};
  assign pref_pending = |pref_req;
  assign force_pref   = (PREF_STARVE != 0) && (starve_q >= StarveMax);

  arb_grant_select #(
    .DemandRr (DEMAND_RR != 0)
  ) u_grant (
    .i_req_i      (i_req),
    .lsq_req_i    (lsq_req),
    .pref_req_i   (pref_req),
    .rr_last_i    (rr_q),
    .force_pref_i (force_pref),
    .grant_o      (grant)
  );

  assign gnt_client = onehot_to_client(grant);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_client != CLI_NONE) begin
          state_d = StBusy;
          owner_d = gnt_client;
          // Write wins when a client raises both strobes.
          case (gnt_client)
            CLI_I: begin
              op_write_d = i_pmem_write_cla;
              addr_d     = i_pmem_address_cla;
              wdata_d    = i_pmem_wdata_256_cla;
            end
            CLI_LSQ: begin
              op_write_d = lsq_pmem_write_cla;
              addr_d     = lsq_pmem_address_cla;
              wdata_d    = lsq_pmem_wdata_256_cla;
            end
            default: begin
              op_write_d = pref_pmem_write_cla;
              addr_d     = pref_pmem_address_cla;
              wdata_d    = pref_pmem_wdata_256_cla;
            end
          endcase
          if (gnt_client == CLI_PREF) begin
            starve_d = '0;
          end else begin
            rr_d = gnt_client;
            if (pref_pending && (starve_q < StarveMax)) begin
              starve_d = starve_q + StarveW'(1);
            end
          end
        end
      end
      StBusy: begin
        if (pmem_resp) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (!pref_pending) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_q    <= CLI_NONE;
      rr_q       <= CLI_I;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
    end
  end

  assign busy   = (state_q == StBusy);
  assign finish = busy && pmem_resp;

  always_comb begin
    arbiter_idle   = (state_q == StIdle);
    pmem_read      = busy && !op_write_q;
    pmem_write     = busy && op_write_q;
    pmem_address   = addr_q;
    pmem_wdata_256 = wdata_q;

    i_pmem_resp_cla    = finish && (owner_q == CLI_I);
    lsq_pmem_resp_cla  = finish && (owner_q == CLI_LSQ);
    pref_pmem_resp_cla = finish && (owner_q == CLI_PREF);

    i_pmem_rdata_256_cla    = i_pmem_resp_cla    ? pmem_rdata_256 : '0;
    lsq_pmem_rdata_256_cla  = lsq_pmem_resp_cla  ? pmem_rdata_256 : '0;
    pref_pmem_rdata_256_cla = pref_pmem_resp_cla ? pmem_rdata_256 : '0;
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: instance 0 is round-robin with PREF_STARVE=3,
// instance 1 is LSQ-priority with no prefetch forcing; both share clock and reset.
module tb_cacheline_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Per instance [d] and per client [c]: 0 = icache, 1 = LSQ, 2 = prefetcher.
  logic         rd     [2][3];
  logic         wr     [2][3];
  logic [31:0]  addr   [2][3];
  logic [255:0] wd     [2][3];
  logic         resp   [2][3];
  logic [255:0] rdata  [2][3];
  logic         idle   [2];
  logic         p_rd   [2];
  logic         p_wr   [2];
  logic [31:0]  p_addr [2];
  logic [255:0] p_wd   [2];
  logic         p_resp [2];
  logic [255:0] p_rdata[2];

  for (genvar gd = 0; gd < 2; gd++) begin : g_dut
    cacheline_arbiter #(
      .ADDR_W      (32),
      .LINE_W      (256),
      .DEMAND_RR   ((gd == 0) ? 1 : 0),
      .PREF_STARVE ((gd == 0) ? 3 : 0)
    ) u_dut (
      .clk                     (clk),
      .rst                     (rst),
      .i_pmem_read_cla         (rd[gd][0]),
      .i_pmem_write_cla        (wr[gd][0]),
      .i_pmem_address_cla      (addr[gd][0]),
      .i_pmem_wdata_256_cla    (wd[gd][0]),
      .i_pmem_resp_cla         (resp[gd][0]),
      .i_pmem_rdata_256_cla    (rdata[gd][0]),
      .lsq_pmem_read_cla       (rd[gd][1]),
      .lsq_pmem_write_cla      (wr[gd][1]),
      .lsq_pmem_address_cla    (addr[gd][1]),
      .lsq_pmem_wdata_256_cla  (wd[gd][1]),
      .lsq_pmem_resp_cla       (resp[gd][1]),
      .lsq_pmem_rdata_256_cla  (rdata[gd][1]),
      .pref_pmem_read_cla      (rd[gd][2]),
      .pref_pmem_write_cla     (wr[gd][2]),
      .pref_pmem_address_cla   (addr[gd][2]),
      .pref_pmem_wdata_256_cla (wd[gd][2]),
      .pref_pmem_resp_cla      (resp[gd][2]),
      .pref_pmem_rdata_256_cla (rdata[gd][2]),
      .arbiter_idle            (idle[gd]),
      .pmem_read               (p_rd[gd]),
      .pmem_write              (p_wr[gd]),
      .pmem_address            (p_addr[gd]),
      .pmem_wdata_256          (p_wd[gd]),
      .pmem_resp               (p_resp[gd]),
      .pmem_rdata_256          (p_rdata[gd])
    );
  end

  int total = 0;
  int bad   = 0;
  int order_q[$];
  int exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] base_addr(input int c);
    if (c == 0) return 32'h0000_1000;
    if (c == 1) return 32'h0000_2040;
    return 32'h0000_3000;
  endfunction

  function automatic logic [255:0] base_wd(input int c);
    if (c == 0) return {32{8'h11}};
    if (c == 1) return {32{8'h55}};
    return {32{8'h77}};
  endfunction

  // Grant rules: forced prefetch, then demand (RR or LSQ-first), then prefetch.
  function automatic int pick(input int d, input bit r0, input bit r1, input bit r2,
                              input bit last_lsq, input int starve);
    int ps;
    bit rr;
    ps = (d == 0) ? 3 : 0;
    rr = (d == 0);
    if (r2 && ps > 0 && starve >= ps) return 2;
    if (r0 && r1) return (rr && last_lsq) ? 0 : 1;
    if (r1) return 1;
    if (r0) return 0;
    if (r2) return 2;
    return -1;
  endfunction

  task automatic clr_inputs();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        rd[d][c]   = 1'b0;
        wr[d][c]   = 1'b0;
        addr[d][c] = '0;
        wd[d][c]   = '0;
      end
      p_resp[d]  = 1'b0;
      p_rdata[d] = rnd256();
    end
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cmp_order(input string nm);
    chk({nm, "_len"}, 256'(order_q.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < order_q.size(); i++)
      chk($sformatf("%s_grant%0d", nm, i), 256'(order_q[i]), 256'(exp_q[i]));
  endtask

  // Cycle-level client/pmem driver with a timing model: grant in an idle cycle g,
  // busy g+1..r (resp at r), done r+1, idle again from r+2.
  task automatic run_scn(input int d, input int n_i, input int n_l, input int n_p,
                         input bit rnd);
    int left[3];
    bit act[3];
    int cool[3];
    int op[3];
    int seq[3];
    logic [31:0]  ta[3];
    logic [255:0] tw[3];
    int own, g_cyc, r_cyc, m_op, starve, g, ps, cyc;
    logic [31:0]  m_a;
    logic [255:0] m_w;
    bit last_lsq, busy_ph, done_ph, all_done;
    string nm;
    ps = (d == 0) ? 3 : 0;
    left[0] = n_i; left[1] = n_l; left[2] = n_p;
    for (int c = 0; c < 3; c++) begin
      act[c] = 0; cool[c] = 0; seq[c] = 0; op[c] = 0; ta[c] = '0; tw[c] = '0;
    end
    own = -1; g_cyc = 0; r_cyc = 0; m_op = 0; m_a = '0; m_w = '0;
    starve = 0; last_lsq = 0; all_done = 0;
    nm = $sformatf("scn_d%0d", d);
    order_q.delete();
    for (cyc = 0; cyc < 4000; cyc++) begin
      all_done = (own < 0);
      for (int c = 0; c < 3; c++) if (left[c] > 0 || act[c]) all_done = 0;
      if (all_done) break;
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (!act[c]) begin
          if (cool[c] > 0) cool[c]--;
          else if (left[c] > 0) begin
            act[c] = 1;
            op[c]  = rnd ? $urandom_range(0, 2) : 0;
            ta[c]  = rnd ? $urandom() : base_addr(c) + 32'(seq[c] * 64);
            tw[c]  = rnd ? rnd256() : base_wd(c);
            seq[c]++;
          end
        end
        rd[d][c]   = act[c] && (op[c] != 1);
        wr[d][c]   = act[c] && (op[c] != 0);
        addr[d][c] = act[c] ? ta[c] : (rnd ? $urandom() : 32'h0);
        wd[d][c]   = act[c] ? tw[c] : (rnd ? rnd256() : '0);
      end
      busy_ph = (own >= 0) && (cyc > g_cyc) && (cyc <= r_cyc);
      done_ph = (own >= 0) && (cyc == r_cyc + 1);
      p_resp[d]  = busy_ph ? (cyc == r_cyc) : (rnd && $urandom_range(0, 3) == 0);
      p_rdata[d] = rnd256();
      @(negedge clk);
      if (!act[2]) starve = 0;
      if (busy_ph) begin
        chk({nm, "_busy_idle"}, idle[d], 1'b0);
        chk({nm, "_busy_read"}, p_rd[d], m_op == 0);
        chk({nm, "_busy_write"}, p_wr[d], m_op != 0);
        chk({nm, "_busy_addr"}, p_addr[d], m_a);
        chk({nm, "_busy_wdata"}, p_wd[d], m_w);
        for (int c = 0; c < 3; c++)
          chk($sformatf("%s_busy_resp%0d", nm, c), resp[d][c], (c == own) && (cyc == r_cyc));
        if (cyc == r_cyc) begin
          if (m_op == 0) chk({nm, "_rdata"}, rdata[d][own], p_rdata[d]);
          act[own]  = 0;
          cool[own] = rnd ? $urandom_range(1, 3) : 1;
          left[own]--;
        end
      end else if (done_ph) begin
        chk({nm, "_done_idle"}, idle[d], 1'b0);
        chk({nm, "_done_strobe"}, p_rd[d] | p_wr[d], 1'b0);
        for (int c = 0; c < 3; c++)
          chk($sformatf("%s_done_resp%0d", nm, c), resp[d][c], 1'b0);
        own = -1;
      end else begin
        chk({nm, "_idle"}, idle[d], 1'b1);
        chk({nm, "_idle_strobe"}, p_rd[d] | p_wr[d], 1'b0);
        for (int c = 0; c < 3; c++)
          chk($sformatf("%s_idle_resp%0d", nm, c), resp[d][c], 1'b0);
        g = pick(d, act[0], act[1], act[2], last_lsq, starve);
        if (g >= 0) begin
          order_q.push_back(g);
          own   = g;
          g_cyc = cyc;
          r_cyc = cyc + (rnd ? $urandom_range(1, 4) : 2);
          m_op  = op[g];
          m_a   = ta[g];
          m_w   = tw[g];
          if (g == 2) starve = 0;
          else begin
            last_lsq = (g == 1);
            if (act[2] && starve < ps) starve++;
          end
        end
      end
    end
    chk({nm, "_completed"}, all_done, 1'b1);
    clr_inputs();
  endtask

  typedef struct {
    int         d;
    logic [2:0] rdm;
    logic [2:0] wrm;
    int         exp_c;
    logic       exp_wr;
  } vec_t;

  vec_t vt[9];
  int   d;
  int   cnt_rd, cnt_idle_low, cnt_resp, resp_k, pulses;

  initial begin
    vt[0] = '{0, 3'b001, 3'b000, 0, 1'b0};  // icache alone
    vt[1] = '{0, 3'b011, 3'b000, 1, 1'b0};  // RR after reset: LSQ first
    vt[2] = '{1, 3'b011, 3'b000, 1, 1'b0};  // fixed LSQ priority
    vt[3] = '{0, 3'b101, 3'b000, 0, 1'b0};  // demand beats prefetch
    vt[4] = '{0, 3'b100, 3'b000, 2, 1'b0};  // prefetch alone
    vt[5] = '{0, 3'b000, 3'b010, 1, 1'b1};  // LSQ write
    vt[6] = '{1, 3'b111, 3'b000, 1, 1'b0};
    vt[7] = '{0, 3'b010, 3'b010, 1, 1'b1};  // read+write: write wins
    vt[8] = '{1, 3'b000, 3'b100, 2, 1'b1};  // prefetch write

    // Reset state, with requests and pmem_resp active during reset.
    clr_inputs();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i][0] = 1'b1; rd[i][1] = 1'b1; p_resp[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_idle%0d", i), idle[i], 1'b1);
      chk($sformatf("rst_strobe%0d", i), p_rd[i] | p_wr[i], 1'b0);
      chk($sformatf("rst_addr%0d", i), p_addr[i], 32'h0);
      chk($sformatf("rst_wdata%0d", i), p_wd[i], '0);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("rst_resp%0d_%0d", i, c), resp[i][c], 1'b0);
        chk($sformatf("rst_rdata%0d_%0d", i, c), rdata[i][c], '0);
      end
    end

    // Single-transaction vectors from a fresh reset.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      d = vt[v].d;
      for (int c = 0; c < 3; c++) begin
        rd[d][c]   = vt[v].rdm[c];
        wr[d][c]   = vt[v].wrm[c];
        addr[d][c] = base_addr(c);
        wd[d][c]   = base_wd(c);
      end
      chk($sformatf("v%0d_idle_pre", v), idle[d], 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_read", v), p_rd[d], !vt[v].exp_wr);
      chk($sformatf("v%0d_write", v), p_wr[d], vt[v].exp_wr);
      chk($sformatf("v%0d_addr", v), p_addr[d], base_addr(vt[v].exp_c));
      chk($sformatf("v%0d_wdata", v), p_wd[d], base_wd(vt[v].exp_c));
      chk($sformatf("v%0d_idle_busy", v), idle[d], 1'b0);
      p_rdata[d] = rnd256();
      p_resp[d]  = 1'b1;
      #1;
      for (int c = 0; c < 3; c++)
        chk($sformatf("v%0d_resp%0d", v, c), resp[d][c], c == vt[v].exp_c);
      if (!vt[v].exp_wr) chk($sformatf("v%0d_rdata", v), rdata[d][vt[v].exp_c], p_rdata[d]);
      @(posedge clk);
      #1;
      clr_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_done_idle", v), idle[d], 1'b0);
      chk($sformatf("v%0d_done_strobe", v), p_rd[d] | p_wr[d], 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", v), idle[d], 1'b1);
    end

    // icache read, pmem_resp on the third busy cycle.
    do_reset();
    rd[0][0] = 1'b1;
    addr[0][0] = 32'h0000_1000;
    cnt_rd = 0; cnt_idle_low = 0; cnt_resp = 0; resp_k = -1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      p_resp[0]  = (k == 3);
      p_rdata[0] = {32{8'hAA}};
      if (k == 4) rd[0][0] = 1'b0;
      @(negedge clk);
      cnt_rd += int'(p_rd[0]);
      cnt_idle_low += int'(!idle[0]);
      if (resp[0][0]) begin
        cnt_resp++;
        resp_k = k;
        chk("t1_rdata", rdata[0][0], {32{8'hAA}});
      end
    end
    chk("t1_read_cycles", 256'(cnt_rd), 256'(3));
    chk("t1_idle_low_cycles", 256'(cnt_idle_low), 256'(4));
    chk("t1_resp_count", 256'(cnt_resp), 256'(1));
    chk("t1_resp_cycle", 256'(resp_k), 256'(3));
    chk("t1_idle_end", idle[0], 1'b1);

    // pmem_resp while idle: ignored.
    do_reset();
    p_resp[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("presp_idle_idle", idle[0], 1'b1);
      chk("presp_idle_resp", resp[0][0] | resp[0][1] | resp[0][2], 1'b0);
      chk("presp_idle_strobe", p_rd[0] | p_wr[0], 1'b0);
    end

    // Asynchronous reset mid-BUSY.
    do_reset();
    rd[0][0] = 1'b1;
    addr[0][0] = 32'h0000_1000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("arst_busy_before", p_rd[0], 1'b1);
    #2;
    rst = 1'b0;
    rd[0][0] = 1'b0;
    #1;
    p_resp[0] = 1'b1;
    #1;
    chk("arst_strobe", p_rd[0] | p_wr[0], 1'b0);
    chk("arst_idle", idle[0], 1'b1);
    chk("arst_resp", resp[0][0], 1'b0);
    chk("arst_addr", p_addr[0], 32'h0);
    p_resp[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      p_resp[0] = ~p_resp[0];
      @(negedge clk);
      pulses += int'(resp[0][0]);
    end
    chk("arst_no_resp", 256'(pulses), 256'(0));
    chk("arst_idle_after", idle[0], 1'b1);
    chk("arst_strobe_after", p_rd[0] | p_wr[0], 1'b0);

    // Demand contention, 4 back-to-back each.
    do_reset();
    run_scn(0, 4, 4, 0, 1'b0);
    exp_q = '{1, 0, 1, 0, 1, 0, 1, 0};
    cmp_order("rr_order");
    do_reset();
    run_scn(1, 4, 4, 0, 1'b0);
    exp_q = '{1, 1, 1, 1, 0, 0, 0, 0};
    cmp_order("fixed_order");

    // Prefetch starvation.
    do_reset();
    run_scn(0, 5, 0, 1, 1'b0);
    exp_q = '{0, 0, 0, 2, 0, 0};
    cmp_order("starve3_order");
    do_reset();
    run_scn(1, 5, 0, 1, 1'b0);
    exp_q = '{0, 0, 0, 0, 0, 2};
    cmp_order("starve0_order");

    // Randomised traffic against the model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      run_scn(0, 10, 10, 8, 1'b1);
      do_reset();
      run_scn(1, 10, 10, 8, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
